// File: rtl/minha_busca.sv
// Instruction fetch stage: reads a 4K-word RAM at the PC and hands the word to a
// consumer over a valid/ready handshake. Optional handshake counter under BUSCA_CONTADOR_EN.
module minha_busca #(
  parameter logic [11:0] PC_INICIAL = 12'h000
) (
  input  logic        relogio_in,
  input  logic        reinicia_in,
  input  logic        carrega_in,
  input  logic [11:0] desvio_in,
  input  logic        pronto_in,
  input  logic [15:0] dado_mem_in,
  output logic [11:0] endereco_out,
  output logic        habilita_out,
  output logic [15:0] instrucao_out,
  output logic [11:0] pc_out,
  output logic        valida_out
`ifdef BUSCA_CONTADOR_EN
  ,
  output logic [15:0] contagem_out
`endif
);

  // Handshake: a word transfers on a rising edge where valida_out=1 and pronto_in=1
  // and no jump or reset is requested; valida_out holds with its data until then.
  typedef enum logic {
    BUSCA   = 1'b0,
    ENTREGA = 1'b1
  } estado_t;

  estado_t     estado_q, estado_d;
  logic [11:0] pc_q, pc_d;
  logic [15:0] instr_q, instr_d;
  logic [11:0] pc_saida_q, pc_saida_d;
  logic        handshake;

  always_comb begin
    estado_d   = estado_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
    pc_saida_d = pc_saida_q;
    handshake  = 1'b0;
    if (carrega_in) begin
      // A jump wins over a pending handshake; the held word is simply abandoned.
      pc_d     = desvio_in;
      estado_d = BUSCA;
    end else begin
      case (estado_q)
        BUSCA: begin
          instr_d    = dado_mem_in;
          pc_saida_d = pc_q;
          estado_d   = ENTREGA;
        end
        ENTREGA: begin
          if (pronto_in) begin
            handshake = 1'b1;
            pc_d      = pc_q + 12'd1;
            estado_d  = BUSCA;
          end
        end
        default: estado_d = BUSCA;
      endcase
    end
  end

  always_ff @(posedge relogio_in) begin
    if (reinicia_in) begin
      estado_q   <= BUSCA;
      pc_q       <= PC_INICIAL;
      instr_q    <= 16'h0000;
      pc_saida_q <= 12'h000;
    end else begin
      estado_q   <= estado_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      pc_saida_q <= pc_saida_d;
    end
  end

`ifdef BUSCA_CONTADOR_EN
  logic [15:0] contagem_q, contagem_d;

  always_comb begin
    contagem_d = contagem_q;
    if (handshake) contagem_d = contagem_q + 16'd1;
  end

  always_ff @(posedge relogio_in) begin
    if (reinicia_in) contagem_q <= 16'h0000;
    else             contagem_q <= contagem_d;
  end

  assign contagem_out = contagem_q;
`else
  logic handshake_sem_uso;
  assign handshake_sem_uso = handshake;
`endif

  // The one-bit state doubles as the valid flag, so valida_out is the FSM debug view.
  assign valida_out    = (estado_q == ENTREGA);
  assign endereco_out  = pc_q;
  assign habilita_out  = 1'b0;
  assign instrucao_out = instr_q;
  assign pc_out        = pc_saida_q;

endmodule

// File: doc/minha_busca.md
MINHA_BUSCA -- requirements
Module: minha_busca

Interface
REQ-001 SHALL have parameter PC_INICIAL, default 12'h000, meaning the program-counter value loaded on reset.
REQ-002 SHALL have port relogio_in, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port reinicia_in, input, 1 bit: reset, synchronous and active-high.
REQ-004 SHALL have port carrega_in, input, 1 bit: jump request; loads the PC from desvio_in.
REQ-005 SHALL have port desvio_in, input, 12 bits: jump target address.
REQ-006 SHALL have port pronto_in, input, 1 bit: consumer ready to accept instrucao_out.
REQ-007 SHALL have port dado_mem_in, input, 16 bits: combinational read data from the 4K-word RAM at endereco_out.
REQ-008 SHALL have port endereco_out, output, 12 bits: RAM read address.
REQ-009 SHALL have port habilita_out, output, 1 bit: RAM write enable, constant 0.
REQ-010 SHALL have port instrucao_out, output, 16 bits: captured instruction word.
REQ-011 SHALL have port pc_out, output, 12 bits: address from which instrucao_out was fetched.
REQ-012 SHALL have port valida_out, output, 1 bit: instrucao_out and pc_out are valid.

Function
REQ-013 SHALL hold a 12-bit PC register; endereco_out SHALL equal the PC, driven straight from the register.
REQ-014 SHALL implement exactly two states: BUSCA (fetch, valida_out=0) and ENTREGA (deliver, valida_out=1).
REQ-015 In BUSCA, without carrega_in, the block SHALL capture dado_mem_in into instrucao_out and the PC into pc_out at the clock edge, then enter ENTREGA.
REQ-016 In ENTREGA, pronto_in=1 without carrega_in SHALL complete the handshake: PC<=PC+1, state<=BUSCA, valida_out<=0.
REQ-017 In ENTREGA, pronto_in=0 SHALL hold instrucao_out, pc_out, PC and valida_out unchanged, even if RAM contents change.
REQ-018 PC increment SHALL wrap from 12'hFFF to 12'h000 with no flag.
REQ-019 Throughput SHALL be one instruction per 2 cycles when pronto_in is held at 1; latency from address presentation to valida_out=1 SHALL be 1 cycle.
REQ-020 carrega_in=1 SHALL, in any state, set PC<=desvio_in, state<=BUSCA, valida_out<=0, and SHALL discard any pending instruction.
REQ-021 A simultaneous carrega_in=1 and pronto_in=1 in ENTREGA SHALL be treated as a jump only; the handshake is not counted and PC is not incremented.
REQ-022 pronto_in SHALL be ignored in BUSCA.

Reset
REQ-023 reinicia_in=1 at a clock edge SHALL set PC<=PC_INICIAL, state<=BUSCA, valida_out<=0, instrucao_out<=0, and pc_out<=0.
REQ-024 reinicia_in SHALL take priority over carrega_in and pronto_in; reset asserted mid-handshake SHALL drop the pending instruction.
REQ-025 In the cycle after reset deasserts, the block SHALL fetch from PC_INICIAL.

Configuration
REQ-026 With macro BUSCA_CONTADOR_EN defined, the block SHALL add output contagem_out, 16 bits, counting completed handshakes (REQ-016 only).
REQ-027 contagem_out SHALL reset to 0 and wrap from 16'hFFFF to 0; jumps and resets SHALL NOT increment it.
REQ-028 Without BUSCA_CONTADOR_EN, contagem_out and its register SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-029 RAM[0..3]=16'h1111,2222,3333,4444; reset; pronto_in=1 -> valida_out pulses every 2nd cycle with (pc_out, instrucao_out) = (0,1111), (1,2222), (2,3333), (3,4444).
REQ-030 pronto_in=0 for 5 cycles in ENTREGA at pc_out=2, while RAM[2] is rewritten to 16'hBEEF -> instrucao_out stays 16'h3333 and valida_out stays 1 for all 5 cycles.
REQ-031 PC=12'hFFF with pronto_in=1 -> instrucao_out = RAM[12'hFFF], then the next fetch has pc_out=12'h000.
REQ-032 In ENTREGA, carrega_in=1, pronto_in=1, desvio_in=12'h123 -> next valida_out has pc_out=12'h123; with BUSCA_CONTADOR_EN, contagem_out is unchanged by that cycle.
REQ-033 reinicia_in=1 together with carrega_in=1 while valida_out=1 -> next cycle valida_out=0, endereco_out=PC_INICIAL, instrucao_out=0, contagem_out=0.
REQ-034 With BUSCA_CONTADOR_EN and contagem_out=16'hFFFF, one handshake -> contagem_out=16'h0000; habilita_out reads 0 throughout every scenario.
